// File: rtl/bpu_pkg.sv
// Shared constants for the branch prediction unit.
//   BHT_*        : 2-bit saturating counter encodings
//   BHT_RESET    : counter value loaded into every BHT entry on reset
//   PC_INCREMENT : fall-through distance used for the not-taken next PC
package bpu_pkg;

  localparam logic [1:0] BHT_STRONG_NT = 2'b00;
  localparam logic [1:0] BHT_WEAK_NT   = 2'b01;
  localparam logic [1:0] BHT_WEAK_T    = 2'b10;
  localparam logic [1:0] BHT_STRONG_T  = 2'b11;

  localparam logic [1:0] BHT_RESET     = BHT_WEAK_NT;

  localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/BRU facing bus of the branch predictor.
//   master : fetch + BRU side, drives lookup PC and resolved-branch feedback
//   slave  : predictor side, returns prediction, predicted next PC and BTB hit
interface branch_predictor_if #(
  parameter int XLEN = 32
);

  logic [XLEN-1:0] bpu_lookup_pc_in;
  logic            bpu_prediction_out;
  logic [XLEN-1:0] bpu_target_out;
  logic            bpu_hit_out;

  logic [XLEN-1:0] bpu_update_pc_in;
  logic            bpu_feedback_result_in;
  logic            bpu_feedback_write_en_in;
  logic [XLEN-1:0] bpu_update_target_in;

  modport master (
    output bpu_lookup_pc_in,
    output bpu_update_pc_in,
    output bpu_feedback_result_in,
    output bpu_feedback_write_en_in,
    output bpu_update_target_in,
    input  bpu_prediction_out,
    input  bpu_target_out,
    input  bpu_hit_out
  );

  modport slave (
    input  bpu_lookup_pc_in,
    input  bpu_update_pc_in,
    input  bpu_feedback_result_in,
    input  bpu_feedback_write_en_in,
    input  bpu_update_target_in,
    output bpu_prediction_out,
    output bpu_target_out,
    output bpu_hit_out
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
//   count_in  : current counter value
//   taken_in  : resolved outcome, 1 = taken (count up)
//   count_out : next counter value, clamped at 00 and 11
module sat_counter2
  import bpu_pkg::*;
(
  input  logic [1:0] count_in,
  input  logic       taken_in,
  output logic [1:0] count_out
);

  always_comb begin
    count_out = count_in;
    if (taken_in) begin
      if (count_in != BHT_STRONG_T) count_out = count_in + 2'd1;
    end else begin
      if (count_in != BHT_STRONG_NT) count_out = count_in - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit BHT plus direct-mapped BTB.
//   clk_in / rst_in : core clock, asynchronous active-high reset
//   bpu (slave)     : combinational lookup (prediction, next PC, BTB hit)
//                     and BRU feedback updating the tables on the clock edge
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  branch_predictor_if.slave  bpu
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  logic [1:0]       bht_q    [ENTRIES];
  logic [1:0]       bht_d    [ENTRIES];
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]    up_tag;
  logic [1:0]          bht_next;
  logic                lk_hit;
  logic                lk_taken;

  // Byte offset of the PC carries no information for word-aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bpu.bpu_lookup_pc_in[1:0], bpu.bpu_update_pc_in[1:0]};

  assign lk_idx = bpu.bpu_lookup_pc_in[IDX_BITS+1:2];
  assign lk_tag = bpu.bpu_lookup_pc_in[XLEN-1:IDX_BITS+2];
  assign up_idx = bpu.bpu_update_pc_in[IDX_BITS+1:2];
  assign up_tag = bpu.bpu_update_pc_in[XLEN-1:IDX_BITS+2];

  // Lookup reads registered state only, so an update in the same cycle is
  // not bypassed. A taken counter without a BTB hit still predicts
  // not-taken because there is no target to redirect to.
  always_comb begin
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && bht_q[lk_idx][1];
    bpu.bpu_hit_out        = lk_hit;
    bpu.bpu_prediction_out = lk_taken;
    if (lk_taken) bpu.bpu_target_out = target_q[lk_idx];
    else          bpu.bpu_target_out = bpu.bpu_lookup_pc_in + XLEN'(PC_INCREMENT);
  end

  sat_counter2 u_sat_counter2 (
    .count_in  (bht_q[up_idx]),
    .taken_in  (bpu.bpu_feedback_result_in),
    .count_out (bht_next)
  );

  // Only taken outcomes allocate into the BTB; a not-taken outcome just
  // walks the counter down and leaves any existing target in place.
  always_comb begin
    bht_d    = bht_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (bpu.bpu_feedback_write_en_in) begin
      bht_d[up_idx] = bht_next;
      if (bpu.bpu_feedback_result_in) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = bpu.bpu_update_target_in;
      end
    end
  end

  // Counters and valid bits carry the reset state; reset overrides any
  // concurrent update strobe.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i]   <= BHT_RESET;
        valid_q[i] <= 1'b0;
      end
    end else begin
      bht_q   <= bht_d;
      valid_q <= valid_d;
    end
  end

  // Tag and target are meaningless while the valid bit is clear, so they
  // need no reset.
  always_ff @(posedge clk_in) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic clk_in;
  logic rst_in;
  int   tests_run;
  int   tests_failed;

  branch_predictor_if #(.XLEN(32)) bus ();

  branch_predictor #(.XLEN(32), .IDX_BITS(6)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bpu    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Drives one feedback strobe for exactly one rising edge.
  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    @(negedge clk_in);
    bus.bpu_update_pc_in         = pc;
    bus.bpu_feedback_result_in   = taken;
    bus.bpu_update_target_in     = tgt;
    bus.bpu_feedback_write_en_in = 1'b1;
    @(negedge clk_in);
    bus.bpu_feedback_write_en_in = 1'b0;
  endtask

  task automatic lookup_expect(input string name, input logic [31:0] pc,
                               input logic ep, input logic eh, input logic [31:0] et);
    bus.bpu_lookup_pc_in = pc;
    #1;
    tests_run++;
    if ({bus.bpu_prediction_out, bus.bpu_hit_out, bus.bpu_target_out} !== {ep, eh, et}) begin
      tests_failed++;
      $display("[TB] FAIL %s: got pred=%b hit=%b target=%h, expected pred=%b hit=%b target=%h",
               name, bus.bpu_prediction_out, bus.bpu_hit_out, bus.bpu_target_out, ep, eh, et);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    bus.bpu_feedback_write_en_in = 1'b0;
    bus.bpu_feedback_result_in   = 1'b0;
    bus.bpu_update_pc_in         = '0;
    bus.bpu_update_target_in     = '0;
    bus.bpu_lookup_pc_in         = 32'h100;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    lookup_expect("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
  endtask

  task automatic test_bht_counting();
    do_update(32'h100, 1'b1, 32'h200);
    lookup_expect("taken1", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h100, 1'b1, 32'h200);
    lookup_expect("taken2", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h100, 1'b1, 32'h200);
    lookup_expect("taken3", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h100, 1'b0, 32'h0);
    lookup_expect("nt1_from_sat", 32'h100, 1'b1, 1'b1, 32'h200);
    do_update(32'h100, 1'b0, 32'h0);
    lookup_expect("nt2_weak_nt", 32'h100, 1'b0, 1'b1, 32'h104);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk_in);
    lookup_expect("pre_reset_hit", 32'h100, 1'b0, 1'b1, 32'h104);
    #2;
    bus.bpu_update_pc_in         = 32'h100;
    bus.bpu_feedback_result_in   = 1'b1;
    bus.bpu_update_target_in     = 32'h200;
    bus.bpu_feedback_write_en_in = 1'b1;
    rst_in = 1'b1;
    lookup_expect("async_reset_drop", 32'h100, 1'b0, 1'b0, 32'h104);
    @(negedge clk_in);
    rst_in = 1'b0;
    bus.bpu_feedback_write_en_in = 1'b0;
    lookup_expect("post_reset_invalid", 32'h100, 1'b0, 1'b0, 32'h104);
    do_update(32'h100, 1'b1, 32'h200);
    lookup_expect("post_reset_weak_nt", 32'h100, 1'b1, 1'b1, 32'h200);
  endtask

  task automatic test_aliasing();
    do_update(32'h100, 1'b1, 32'h200);
    do_update(32'h200, 1'b1, 32'h300);
    lookup_expect("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
    lookup_expect("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
  endtask

  task automatic test_same_cycle();
    @(negedge clk_in);
    bus.bpu_update_pc_in         = 32'h40;
    bus.bpu_feedback_result_in   = 1'b1;
    bus.bpu_update_target_in     = 32'h80;
    bus.bpu_feedback_write_en_in = 1'b1;
    lookup_expect("same_cycle_old", 32'h40, 1'b0, 1'b0, 32'h44);
    @(negedge clk_in);
    bus.bpu_feedback_write_en_in = 1'b0;
    lookup_expect("same_cycle_next", 32'h40, 1'b1, 1'b1, 32'h80);
  endtask

  task automatic test_saturation_wrap();
    do_update(32'h10, 1'b1, 32'h500);
    do_update(32'h10, 1'b1, 32'h500);
    for (int i = 0; i < 5; i++) do_update(32'h10, 1'b0, 32'h0);
    do_update(32'h10, 1'b1, 32'h500);
    lookup_expect("sat_low_then_taken", 32'h10, 1'b0, 1'b1, 32'h14);
    do_update(32'h10, 1'b1, 32'h500);
    lookup_expect("sat_low_taken2", 32'h10, 1'b1, 1'b1, 32'h500);
    lookup_expect("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);
    lookup_expect("taken_ignores_low_bits", 32'h13, 1'b1, 1'b1, 32'h500);
  endtask

  task automatic test_back_to_back();
    @(negedge clk_in);
    bus.bpu_update_pc_in         = 32'h20;
    bus.bpu_feedback_result_in   = 1'b1;
    bus.bpu_update_target_in     = 32'h600;
    bus.bpu_feedback_write_en_in = 1'b1;
    repeat (2) @(negedge clk_in);
    bus.bpu_feedback_write_en_in = 1'b0;
    do_update(32'h20, 1'b0, 32'h0);
    lookup_expect("held_we_two_steps", 32'h20, 1'b1, 1'b1, 32'h600);
    @(negedge clk_in);
    lookup_expect("we_low_no_change", 32'h20, 1'b1, 1'b1, 32'h600);
    do_update(32'h20, 1'b0, 32'h0);
    lookup_expect("back_to_back_weak_nt", 32'h20, 1'b0, 1'b1, 32'h24);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_bht_counting();
    test_reset_mid_run();
    test_aliasing();
    test_same_cycle();
    test_saturation_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
